wx_mem_reader: RTL and testbench

//  Read-side sequencer for the weight/activation memory system that the load path fills via
//  w_sel/w_addr/x_sel/x_addr. On start, walks all 4 layers in order, issuing paired weight and

---
 rtl/wx_nn_pkg.sv | 32 +++
 rtl/wx_beat_fifo.sv | 64 ++++++
 rtl/wx_mem_reader.sv | 200 ++++++++++++++++++++
 tb/tb_wx_mem_reader.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/wx_nn_pkg.sv
// ---------------------------------------------------------------------------
// wx_nn_pkg
//   Shared definitions for the binary-network memory system: layer geometry
//   constants, fan-in/fan-out lookup helpers and the read sequencer FSM
//   state encoding. Used by the load path, the read sequencer and compute.
//   No ports (package).
// ---------------------------------------------------------------------------
package wx_nn_pkg;

   localparam int N_IN0    = 784;   // layer-0 fan-in
   localparam int N_HID    = 1024;  // hidden width
   localparam int N_OUT    = 10;    // layer-3 outputs
   localparam int N_LAYERS = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } wx_state_t;

   // Inputs per neuron of a layer: layer 0 sees the image, the rest see a hidden layer.
   function automatic int fanin(input int layer, input int n_in0, input int n_hid);
      return (layer == 0) ? n_in0 : n_hid;
   endfunction

   // Neurons in a layer: only the last layer is narrow.
   function automatic int fanout(input int layer, input int n_hid, input int n_out);
      return (layer == N_LAYERS - 1) ? n_out : n_hid;
   endfunction

endpackage

// File: rtl/wx_beat_fifo.sv
// ---------------------------------------------------------------------------
// wx_beat_fifo
//   2-entry registered FIFO holding (w, x, layer, neuron, first, last) beats
//   between the memory return path and the valid/ready output.
//   Ports:
//     clk, rst     clock, synchronous active-high reset
//     push, din    write side (dropped only if full without a same-cycle pop)
//     pop          read side (ignored when empty)
//     dout         head entry, straight from storage
//     count        occupancy 0..2
//     full, empty  occupancy flags
// ---------------------------------------------------------------------------
module wx_beat_fifo
   import wx_nn_pkg::*;
#(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic [W-1:0] din,
   input  logic         pop,
   output logic [W-1:0] dout,
   output logic [1:0]   count,
   output logic         full,
   output logic         empty
);

   logic [W-1:0] mem [2];
   logic         wr_ptr;
   logic         rd_ptr;
   logic         do_push;
   logic         do_pop;

   assign full    = (count == 2'd2);
   assign empty   = (count == 2'd0);
   assign do_pop  = pop & ~empty;
   // When full, a same-cycle pop frees the slot the write pointer lands on.
   assign do_push = push & (~full | do_pop);
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         mem[0] <= '0;
         mem[1] <= '0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= ~wr_ptr;
         end
         if (do_pop)
            rd_ptr <= ~rd_ptr;
         case ({do_push, do_pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/wx_mem_reader.sv
// ---------------------------------------------------------------------------
// wx_mem_reader
//   Read-side sequencer: on start walks layers 0..3, neurons, inputs in that
//   order, issuing paired weight/activation reads and streaming the returned
//   bits with layer/neuron/first/last tags over valid/ready.
//   Ports:
//     clk, rst            clock, synchronous active-high reset
//     start               pulse, accepted only when idle
//     busy, done          pass in progress / 1-cycle completion pulse
//     w_sel, w_addr       weight bank select and address (registered)
//     w_data              weight bit, 1 cycle after the address
//     x_sel, x_addr       activation bank select and address (registered)
//     x_data              activation bit, 1 cycle after the address
//     out_valid/out_ready beat handshake
//     out_w, out_x        data bits of the beat
//     out_layer/neuron    tags of the beat
//     out_first/last      beat is input 0 / input fanin-1 of the neuron
// ---------------------------------------------------------------------------
module wx_mem_reader #(
   parameter int W_ADDR_LEN = 20,
   parameter int X_ADDR_LEN = 10,
   parameter int SEL_LEN    = 2,
   parameter int N_IN0      = wx_nn_pkg::N_IN0,
   parameter int N_HID      = wx_nn_pkg::N_HID,
   parameter int N_OUT      = wx_nn_pkg::N_OUT
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   output logic                  busy,
   output logic                  done,
   output logic [SEL_LEN-1:0]    w_sel,
   output logic [W_ADDR_LEN-1:0] w_addr,
   input  logic                  w_data,
   output logic [SEL_LEN-1:0]    x_sel,
   output logic [X_ADDR_LEN-1:0] x_addr,
   input  logic                  x_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  out_w,
   output logic                  out_x,
   output logic [SEL_LEN-1:0]    out_layer,
   output logic [X_ADDR_LEN-1:0] out_neuron,
   output logic                  out_first,
   output logic                  out_last
);

   import wx_nn_pkg::*;

   localparam int BW = 1 + 1 + SEL_LEN + X_ADDR_LEN + 2;

   wx_state_t state, state_nxt;

   // Issue counters; the address registers always hold the next read to issue.
   logic [SEL_LEN-1:0]    layer;
   logic [X_ADDR_LEN-1:0] neuron;
   logic [X_ADDR_LEN-1:0] idx;
   logic [W_ADDR_LEN-1:0] base;
   logic [W_ADDR_LEN-1:0] w_addr_q;

   logic [X_ADDR_LEN-1:0] fin_m1;
   logic [X_ADDR_LEN-1:0] fout_m1;
   logic [W_ADDR_LEN-1:0] fin_w;
   logic                  last_i, last_j, last_l, issue_end;
   logic [SEL_LEN-1:0]    nxt_layer;
   logic [X_ADDR_LEN-1:0] nxt_neuron;
   logic [X_ADDR_LEN-1:0] nxt_idx;
   logic [W_ADDR_LEN-1:0] nxt_base;

   // Tags of the read whose data returns this cycle.
   logic                  infl;
   logic [SEL_LEN-1:0]    infl_layer;
   logic [X_ADDR_LEN-1:0] infl_neuron;
   logic                  infl_first;
   logic                  infl_last;

   logic                  run, accept, can_issue, issue, pop;
   logic [BW-1:0]         fifo_din, fifo_dout;
   logic [1:0]            fifo_count;
   logic                  fifo_full, fifo_empty;

   // ---------------- FSM ----------------
   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (start) state_nxt = ST_RUN;
         ST_RUN:   if (issue && issue_end) state_nxt = ST_DRAIN;
         // Finish once the last beat leaves, counting a pop in this cycle.
         ST_DRAIN: if (!infl && (fifo_count == 2'd0 || (fifo_count == 2'd1 && pop)))
                      state_nxt = ST_DONE;
         ST_DONE:  state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      busy   = (state != ST_IDLE);
      done   = (state == ST_DONE);
      run    = (state == ST_RUN);
      accept = (state == ST_IDLE) && start;
   end

   // ---------------- counter stepping ----------------
   always_comb begin
      fin_w   = W_ADDR_LEN'(fanin(int'(layer), N_IN0, N_HID));
      fin_m1  = X_ADDR_LEN'(fanin(int'(layer), N_IN0, N_HID) - 1);
      fout_m1 = X_ADDR_LEN'(fanout(int'(layer), N_HID, N_OUT) - 1);

      last_i    = (idx == fin_m1);
      last_j    = (neuron == fout_m1);
      last_l    = (layer == SEL_LEN'(N_LAYERS - 1));
      issue_end = last_i && last_j && last_l;

      nxt_layer  = layer;
      nxt_neuron = neuron;
      nxt_base   = base;
      nxt_idx    = last_i ? '0 : idx + X_ADDR_LEN'(1);
      if (last_i) begin
         if (last_j) begin
            nxt_neuron = '0;
            nxt_base   = '0;
            nxt_layer  = layer + SEL_LEN'(1);
         end else begin
            nxt_neuron = neuron + X_ADDR_LEN'(1);
            nxt_base   = base + fin_w;
         end
      end
   end

   // Space check: FIFO plus in-flight read must stay within 2 after this cycle's pop.
   assign pop       = out_valid & out_ready;
   assign can_issue = fifo_full ? (pop & ~infl) : (fifo_empty | ~infl | pop);
   assign issue     = run & can_issue;

   always_ff @(posedge clk) begin
      if (rst) begin
         layer       <= '0;
         neuron      <= '0;
         idx         <= '0;
         base        <= '0;
         w_addr_q    <= '0;
         infl        <= 1'b0;
         infl_layer  <= '0;
         infl_neuron <= '0;
         infl_first  <= 1'b0;
         infl_last   <= 1'b0;
      end else begin
         infl <= issue;
         if (issue) begin
            infl_layer  <= layer;
            infl_neuron <= neuron;
            infl_first  <= (idx == '0);
            infl_last   <= last_i;
         end
         if (accept) begin
            layer    <= '0;
            neuron   <= '0;
            idx      <= '0;
            base     <= '0;
            w_addr_q <= '0;
         end else if (issue && !issue_end) begin
            // After the final read the counters freeze on the last address.
            layer    <= nxt_layer;
            neuron   <= nxt_neuron;
            idx      <= nxt_idx;
            base     <= nxt_base;
            w_addr_q <= nxt_base + W_ADDR_LEN'(nxt_idx);
         end
      end
   end

   assign w_sel  = layer;
   assign x_sel  = layer;
   assign w_addr = w_addr_q;
   assign x_addr = idx;

   // ---------------- return path ----------------
   assign fifo_din = {w_data, x_data, infl_layer, infl_neuron, infl_first, infl_last};

   wx_beat_fifo #(.W(BW)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (infl),
      .din   (fifo_din),
      .pop   (pop),
      .dout  (fifo_dout),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign out_valid = ~fifo_empty;
   assign {out_w, out_x, out_layer, out_neuron, out_first, out_last} = fifo_dout;

endmodule

// File: tb/tb_wx_mem_reader.sv
// ---------------------------------------------------------------------------
// tb_wx_mem_reader
//   Bench for wx_mem_reader in a small geometry (3 inputs, 2 hidden, 2 out,
//   18 beats per pass). A 1-cycle ROM returns w=w_addr[0], x=x_addr[1];
//   expected beats are queued per pass and popped on each handshake.
// ---------------------------------------------------------------------------
module tb_wx_mem_reader;

   localparam int NI0 = 3;
   localparam int NH  = 2;
   localparam int NO  = 2;
   localparam int WA  = 20;
   localparam int XA  = 10;
   localparam int SL  = 2;
   localparam int NBEATS = 18;

   logic          clk = 1'b0;
   logic          rst, start;
   logic          busy, done;
   logic [SL-1:0] w_sel, x_sel;
   logic [WA-1:0] w_addr;
   logic [XA-1:0] x_addr;
   logic          w_data = 1'b0, x_data = 1'b0;
   logic          out_valid, out_ready;
   logic          out_w, out_x, out_first, out_last;
   logic [SL-1:0] out_layer;
   logic [XA-1:0] out_neuron;

   int tests = 0, fails = 0;
   int cyc = 0;
   int beat_cnt, done_cnt, done_cyc, first_cyc, last_cyc;
   logic [15:0] exp_q[$];
   logic [15:0] held;
   bit          stalled = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // 1-cycle synchronous ROM
   always @(posedge clk) begin
      w_data <= w_addr[0];
      x_data <= x_addr[1];
   end

   wx_mem_reader #(
      .W_ADDR_LEN(WA), .X_ADDR_LEN(XA), .SEL_LEN(SL),
      .N_IN0(NI0), .N_HID(NH), .N_OUT(NO)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
      .w_sel(w_sel), .w_addr(w_addr), .w_data(w_data),
      .x_sel(x_sel), .x_addr(x_addr), .x_data(x_data),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_w(out_w), .out_x(out_x), .out_layer(out_layer),
      .out_neuron(out_neuron), .out_first(out_first), .out_last(out_last)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int fi(input int l);
      return (l == 0) ? NI0 : NH;
   endfunction

   function automatic int fo(input int l);
      return (l == 3) ? NO : NH;
   endfunction

   function automatic logic [15:0] beat_now();
      return {out_w, out_x, out_layer, out_neuron, out_first, out_last};
   endfunction

   task automatic push_expected();
      for (int l = 0; l < 4; l++) begin
         int base;
         base = 0;
         for (int j = 0; j < fo(l); j++) begin
            for (int i = 0; i < fi(l); i++) begin
               int wa;
               logic [15:0] b;
               wa = base + i;
               b = {wa[0], i[1], 2'(l), 10'(j), (i == 0), (i == fi(l) - 1)};
               exp_q.push_back(b);
            end
            base += fi(l);
         end
      end
   endtask

   // Output monitor: scoreboard pop on handshake, stability while stalled.
   always @(negedge clk) begin
      if (rst) begin
         stalled = 0;
      end else begin
         if (stalled) begin
            check("stall_valid", {31'd0, out_valid}, 32'd1);
            check("stall_fields", {16'd0, beat_now()}, {16'd0, held});
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               check("extra_beat", 32'd1, 32'd0);
            end else begin
               logic [15:0] e;
               e = exp_q.pop_front();
               check($sformatf("beat%0d", beat_cnt), {16'd0, beat_now()}, {16'd0, e});
            end
            if (beat_cnt == 0) first_cyc = cyc;
            last_cyc = cyc;
            beat_cnt++;
         end
         stalled = out_valid && !out_ready;
         held    = beat_now();
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
         end
      end
   end

   task automatic clear_stats();
      beat_cnt = 0; done_cnt = 0; done_cyc = -1; first_cyc = -1; last_cyc = -1;
   endtask

   task automatic run_pass(input string nm, input bit rnd, input bit restart);
      bit pulsed;
      int n;
      pulsed = 0;
      push_expected();
      clear_stats();
      out_ready = 1'b1;
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      if (!rnd) begin
         check({nm, "_busy_rise"}, {31'd0, busy}, 32'd1);
         check({nm, "_valid_c0"}, {31'd0, out_valid}, 32'd0);
         @(posedge clk); #1;
         check({nm, "_valid_c1"}, {31'd0, out_valid}, 32'd0);
         @(posedge clk); #1;
         check({nm, "_valid_c2"}, {31'd0, out_valid}, 32'd1);
      end
      n = 0;
      while (done_cnt == 0 && n < 2000) begin
         if (rnd) out_ready = ($urandom_range(99) >= 30);
         if (restart && !pulsed && beat_cnt >= 5) begin
            start  = 1'b1;
            pulsed = 1;
         end else begin
            start = 1'b0;
         end
         @(posedge clk); #1;
         n++;
      end
      start     = 1'b0;
      out_ready = 1'b1;
      check({nm, "_done_seen"}, {31'd0, done_cnt > 0}, 32'd1);
      repeat (5) @(posedge clk);
      #1;
      check({nm, "_beats"}, beat_cnt, NBEATS);
      check({nm, "_done_once"}, done_cnt, 1);
      check({nm, "_queue_empty"}, exp_q.size(), 0);
      check({nm, "_done_timing"}, done_cyc, last_cyc + 1);
      check({nm, "_idle"}, {31'd0, busy}, 32'd0);
      check({nm, "_end_waddr"}, {12'd0, w_addr}, 32'd3);
      check({nm, "_end_xaddr"}, {22'd0, x_addr}, 32'd1);
      check({nm, "_end_sel"}, {28'd0, w_sel, x_sel}, 32'hF);
      if (!rnd)
         check({nm, "_no_gaps"}, last_cyc - first_cyc, NBEATS - 1);
      exp_q.delete();
   endtask

   initial begin
      int n;
      rst = 1'b1; start = 1'b0; out_ready = 1'b1;
      clear_stats();
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_valid", {31'd0, out_valid}, 32'd0);
      check("rst_waddr", {12'd0, w_addr}, 32'd0);
      check("rst_xaddr", {22'd0, x_addr}, 32'd0);
      check("rst_sel", {28'd0, w_sel, x_sel}, 32'd0);
      check("rst_tags", {16'd0, beat_now()}, 32'd0);
      rst = 1'b0;

      run_pass("ready1", 0, 0);
      run_pass("rand30", 1, 0);
      run_pass("restart", 0, 1);

      // Abort during layer 1, then a clean pass.
      push_expected();
      clear_stats();
      out_ready = 1'b1;
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      n = 0;
      while (beat_cnt < 8 && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      check("abort_in_l1", {31'd0, beat_cnt >= 8}, 32'd1);
      rst = 1'b1;
      @(posedge clk); #1;
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_valid", {31'd0, out_valid}, 32'd0);
      rst = 1'b0;
      exp_q.delete();
      clear_stats();
      repeat (3) @(posedge clk);
      #1;
      check("abort_no_done", done_cnt, 0);
      check("abort_dropped", {31'd0, out_valid}, 32'd0);

      run_pass("after_abort", 0, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
